// File: rtl/gray_sobel_edge_pkg.sv
// Shared constants for the gray-to-Sobel edge stage: default image geometry,
// sample width, derived counter widths and the gradient/magnitude width.
package gray_sobel_edge_pkg;

    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;
    localparam int DEF_DW    = 12;

    localparam int DEF_COL_W = $clog2(DEF_IMG_W);
    localparam int DEF_ROW_W = $clog2(DEF_IMG_H);

    // Gx/Gy need sign + 2 growth bits over the sample width; |Gx|+|Gy| fits
    // in the same number of unsigned bits.
    localparam int MAG_EXTRA = 3;
    localparam int DEF_MAG_W = DEF_DW + MAG_EXTRA;

    // Address/counter width for a range of n values (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of gray samples. Single port with read-before-write: a
// write to an address returns the value it replaces on the same access.
module sobel_line_buffer
    import gray_sobel_edge_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_W,
    parameter int DW    = DEF_DW,
    parameter int AW    = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [DEPTH];

    // Registered read of the old contents, optional overwrite, only when enabled.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem_r[addr];
            if (we) begin
                mem_r[addr] <= wdata;
            end
        end
    end

endmodule

// File: rtl/gray_sobel_edge.sv
// 3x3 Sobel edge detector on a raster gray stream. Two ping-pong line buffers
// (row parity selects which one is overwritten) supply the two rows above the
// incoming pixel. Three pipeline stages: buffer read, gradients, magnitude.
module gray_sobel_edge
    import gray_sobel_edge_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int DW    = DEF_DW
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iDVAL,
    input  logic [DW-1:0] iDATA,
    input  logic [DW-1:0] iTHRESH,
    output logic          oDVAL,
    output logic [DW-1:0] oDATA,
    output logic          oEDGE,
    output logic          oFRAME_DONE
);

    localparam int COL_W = cnt_width(IMG_W);
    localparam int ROW_W = cnt_width(IMG_H);
    localparam int MAG_W = DW + MAG_EXTRA;

    // Weighted 1-2-1 sum of three samples, widened to the gradient width.
    function automatic logic signed [MAG_W-1:0] wsum(input logic [DW-1:0] a,
                                                     input logic [DW-1:0] b,
                                                     input logic [DW-1:0] c);
        return $signed({3'b000, a}) + $signed({2'b00, b, 1'b0}) + $signed({3'b000, c});
    endfunction

    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic [DW-1:0]    thresh_r;
    logic             col_last_s, row_last_s, first_s;

    logic [DW-1:0]    rd0_s, rd1_s;
    logic             v1_r, par1_r, border1_r, last1_r;
    logic [DW-1:0]    pix1_r, thr1_r;

    logic [DW-1:0]    top_s, mid_s, bot_s;
    logic [DW-1:0]    wa_t_r, wa_m_r, wa_b_r, wb_t_r, wb_m_r, wb_b_r;
    logic signed [MAG_W-1:0] gx_s, gy_s, gx2_r, gy2_r;
    logic             v2_r, border2_r, last2_r;
    logic [DW-1:0]    thr2_r;

    logic [MAG_W-1:0] ax_s, ay_s, mag_s;
    logic [DW-1:0]    sat_s;

    assign col_last_s = (col_r == COL_W'(IMG_W - 1));
    assign row_last_s = (row_r == ROW_W'(IMG_H - 1));
    assign first_s    = (col_r == '0) && (row_r == '0);

    // Raster position of the next accepted pixel; frozen while iDVAL is low.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            col_r <= '0;
            row_r <= '0;
        end else if (iDVAL) begin
            if (col_last_s) begin
                col_r <= '0;
                row_r <= row_last_s ? '0 : row_r + ROW_W'(1);
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end
    end

    // Frame threshold captured with the first pixel of each frame.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            thresh_r <= '0;
        end else if (iDVAL && first_s) begin
            thresh_r <= iTHRESH;
        end
    end

    // Even rows overwrite buffer 0, odd rows buffer 1; the overwritten value
    // is the row two above, the other buffer holds the row directly above.
    sobel_line_buffer #(.DEPTH(IMG_W), .DW(DW), .AW(COL_W)) u_lb0 (
        .clk(iCLK), .en(iDVAL), .we(iDVAL & ~row_r[0]),
        .addr(col_r), .wdata(iDATA), .rdata(rd0_s)
    );
    sobel_line_buffer #(.DEPTH(IMG_W), .DW(DW), .AW(COL_W)) u_lb1 (
        .clk(iCLK), .en(iDVAL), .we(iDVAL & row_r[0]),
        .addr(col_r), .wdata(iDATA), .rdata(rd1_s)
    );

    // Stage 1: valid plus the pixel and position tags aligned with the buffer reads.
    // The threshold tag travels with the pixel so a new frame's threshold never
    // applies to the tail of the previous frame.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            v1_r      <= 1'b0;
            par1_r    <= 1'b0;
            border1_r <= 1'b0;
            last1_r   <= 1'b0;
            pix1_r    <= '0;
            thr1_r    <= '0;
        end else begin
            v1_r <= iDVAL;
            if (iDVAL) begin
                par1_r    <= row_r[0];
                border1_r <= (row_r < ROW_W'(2)) || (col_r < COL_W'(2));
                last1_r   <= col_last_s && row_last_s;
                pix1_r    <= iDATA;
                thr1_r    <= first_s ? iTHRESH : thresh_r;
            end
        end
    end

    // Newest window column and the two gradients over the full 3x3 window.
    always_comb begin
        top_s = par1_r ? rd1_s : rd0_s;
        mid_s = par1_r ? rd0_s : rd1_s;
        bot_s = pix1_r;
        gx_s  = wsum(top_s, mid_s, bot_s) - wsum(wa_t_r, wa_m_r, wa_b_r);
        gy_s  = wsum(wa_b_r, wb_b_r, bot_s) - wsum(wa_t_r, wb_t_r, top_s);
    end

    // Window shift by one column per accepted pixel; contents are masked at
    // borders so they need no reset.
    always_ff @(posedge iCLK) begin
        if (v1_r) begin
            wa_t_r <= wb_t_r;
            wa_m_r <= wb_m_r;
            wa_b_r <= wb_b_r;
            wb_t_r <= top_s;
            wb_m_r <= mid_s;
            wb_b_r <= bot_s;
        end
    end

    // Stage 2: gradient registers and the tags that travel with them.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            v2_r      <= 1'b0;
            gx2_r     <= '0;
            gy2_r     <= '0;
            border2_r <= 1'b0;
            last2_r   <= 1'b0;
            thr2_r    <= '0;
        end else begin
            v2_r <= v1_r;
            if (v1_r) begin
                gx2_r     <= gx_s;
                gy2_r     <= gy_s;
                border2_r <= border1_r;
                last2_r   <= last1_r;
                thr2_r    <= thr1_r;
            end
        end
    end

    // Absolute values, magnitude and saturation to the sample range.
    always_comb begin
        ax_s  = gx2_r[MAG_W-1] ? MAG_W'(-gx2_r) : MAG_W'(gx2_r);
        ay_s  = gy2_r[MAG_W-1] ? MAG_W'(-gy2_r) : MAG_W'(gy2_r);
        mag_s = ax_s + ay_s;
        if (|mag_s[MAG_W-1:DW]) begin
            sat_s = {DW{1'b1}};
        end else begin
            sat_s = mag_s[DW-1:0];
        end
    end

    // Stage 3: registered outputs; data and edge hold between valid outputs.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oDVAL       <= 1'b0;
            oDATA       <= '0;
            oEDGE       <= 1'b0;
            oFRAME_DONE <= 1'b0;
        end else begin
            oDVAL       <= v2_r;
            oFRAME_DONE <= v2_r & last2_r;
            if (v2_r) begin
                oDATA <= border2_r ? '0 : sat_s;
                oEDGE <= border2_r ? 1'b0 : (sat_s >= thr2_r);
            end
        end
    end

endmodule
